// File: rtl/shift_encoding_pkg.sv
// Shared constants and the rotate helper for the shift encoder.
// Vectors are numeric [63:0]; block bit 0 (MSB) is vector bit 63.
package shift_encoding_pkg;

  localparam int BLOCK_W        = 64;
  localparam int BYTE_W         = 8;
  localparam int SHIFT_W        = 6;
  localparam int ROUNDS_DEFAULT = 64;
  localparam int CNT_W          = 7;
  localparam int IDX_W          = 3;

  // Rotate toward the MSB: block bit i lands at (i-s) mod 64.
  function automatic logic [BLOCK_W-1:0] rotl(
    input logic [BLOCK_W-1:0] x,
    input logic [SHIFT_W-1:0] s
  );
    logic [2*BLOCK_W-1:0] w;
    w = {x, x} << s;
    return w[2*BLOCK_W-1:BLOCK_W];
  endfunction

endpackage

// File: rtl/shift_encoding_round.sv
// shift_round: one combinational round, state' = rotl(state,s) ^ rk.
// Ports: state_i, rk_i, idx_i (key byte) -> state_o, rk_o.
module shift_round
  import shift_encoding_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_i,
  input  logic [BLOCK_W-1:0] rk_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [BLOCK_W-1:0] state_o,
  output logic [BLOCK_W-1:0] rk_o
);

  logic [BLOCK_W-1:0] sel;
  logic [BYTE_W-1:0]  kbyte;
  logic [SHIFT_W-1:0] s;

  // Byte 0 is the most significant byte, so shift it up to the top.
  assign sel   = rk_i << {idx_i, 3'b000};
  assign kbyte = sel[BLOCK_W-1 -: BYTE_W];
  assign s     = kbyte[SHIFT_W-1:0];

  assign state_o = rotl(state_i, s) ^ rk_i;
  assign rk_o    = rotl(rk_i, SHIFT_W'(BYTE_W));

endmodule

// File: rtl/shift_encoding.sv
// shift_encoding: iterative rotate/XOR encoder, ROUNDS rounds per load.
// Ports: clk, rst_n, set, data_in, key -> data_out, status (done).
module shift_encoding
  import shift_encoding_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set,
  input  logic [BLOCK_W-1:0] data_in,
  input  logic [BLOCK_W-1:0] key,
  output logic [BLOCK_W-1:0] data_out,
  output logic               status
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  logic [BLOCK_W-1:0] state_q, state_d;
  logic [BLOCK_W-1:0] rk_q, rk_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [BLOCK_W-1:0] dout_q, dout_d;
  logic               stat_q, stat_d;
  logic [BLOCK_W-1:0] st_nx, rk_nx;

  shift_round u_round (
    .state_i (state_q),
    .rk_i    (rk_q),
    .idx_i   (cnt_q[IDX_W-1:0]),
    .state_o (st_nx),
    .rk_o    (rk_nx)
  );

  // A load always wins, including over the final round.
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    dout_d  = dout_q;
    stat_d  = stat_q;
    if (set) begin
      state_d = data_in;
      rk_d    = key;
      cnt_d   = '0;
      busy_d  = 1'b1;
      stat_d  = 1'b0;
    end else if (busy_q) begin
      state_d = st_nx;
      rk_d    = rk_nx;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        stat_d = 1'b1;
        dout_d = st_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      rk_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
      stat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      stat_q  <= stat_d;
    end
  end

  assign data_out = dout_q;
  assign status   = stat_q;

endmodule

// File: tb/tb_shift_encoding.sv
// Directed bench for shift_encoding with a bit-level golden model.
// Each scenario task drives stimulus and checks its own results.
module tb_shift_encoding;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        set;
  logic [63:0] data_in;
  logic [63:0] key;
  logic [63:0] data_out;
  logic        status;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] D0 = 64'h8967452301efcdab;
  localparam logic [63:0] D1 = 64'h0123456789abcdef;
  localparam logic [63:0] D2 = 64'hdeadbeefcafef00d;
  localparam logic [63:0] K3 = 64'h0102030405060708;
  localparam logic [63:0] K4 = 64'h3f1e2d4c5b6a7988;

  shift_encoding dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set      (set),
    .data_in  (data_in),
    .key      (key),
    .data_out (data_out),
    .status   (status)
  );

  always #5 clk = ~clk;

  // Block bit i (bit 0 = MSB) moves to block position (i-s) mod 64.
  function automatic logic [63:0] m_rotl(logic [63:0] x, int s);
    logic [63:0] y;
    int p;
    for (int i = 0; i < 64; i++) begin
      p = (i - s + 64) % 64;
      y[63-p] = x[63-i];
    end
    return y;
  endfunction

  function automatic logic [63:0] m_enc(logic [63:0] d, logic [63:0] k,
                                        int n);
    logic [63:0] st, rk, b;
    int j, s;
    st = d;
    rk = k;
    for (int r = 0; r < n; r++) begin
      j = r % 8;
      b = (rk >> (56 - 8*j)) & 64'hff;
      s = int'(b) % 64;
      st = m_rotl(st, s) ^ rk;
      rk = m_rotl(rk, 8);
    end
    return st;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(logic [63:0] d, logic [63:0] k, int hold);
    data_in = d;
    key     = k;
    set     = 1'b1;
    repeat (hold) tick();
    set = 1'b0;
  endtask

  // Edges until status rises, counted from the first set=0 edge.
  task automatic wait_done(output int n);
    n = 0;
    while (1) begin
      tick();
      n++;
      if (status) break;
      if (n >= 200) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; set = 1'b0; data_in = '0; key = '0;
    #3;
    checks++;
    if (data_out !== 64'h0 || status !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: data_out=%h status=%b want 0/0",
               data_out, status);
    end
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (data_out !== 64'h0 || status !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: data_out=%h status=%b want 0/0",
               data_out, status);
    end
  endtask

  task automatic test_key_zero();
    int n;
    load(D0, 64'h0, 1);
    wait_done(n);
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL key0_latency: edges=%0d want 64", n);
    end
    checks++;
    if (data_out !== D0) begin
      errors++;
      $display("FAIL key0_data: got %h want %h", data_out, D0);
    end
  endtask

  task automatic test_key_40();
    int n;
    load(D0, 64'h4040404040404040, 1);
    wait_done(n);
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL key40_latency: edges=%0d want 64", n);
    end
    checks++;
    if (data_out !== D0) begin
      errors++;
      $display("FAIL key40_data: got %h want %h", data_out, D0);
    end
  endtask

  task automatic test_rot8();
    logic [63:0] k;
    logic [63:0] exp;
    k = 64'h0808080808080808;
    load(D0, k, 1);
    for (int r = 1; r <= 64; r++) begin
      tick();
      exp = m_enc(D0, k, r);
      checks++;
      if (dut.state_q !== exp) begin
        errors++;
        $display("FAIL rot8_round%0d: state=%h want %h",
                 r, dut.state_q, exp);
      end
    end
    checks++;
    if (status !== 1'b1 || data_out !== D0) begin
      errors++;
      $display("FAIL rot8_done: data_out=%h status=%b want %h/1",
               data_out, status, D0);
    end
  endtask

  task automatic test_mixed();
    int n;
    logic [63:0] exp;
    exp = m_enc(D0, K3, 64);
    load(D0, K3, 1);
    wait_done(n);
    checks++;
    if (n !== 64 || data_out !== exp) begin
      errors++;
      $display("FAIL mixed_result: edges=%0d data=%h want 64/%h",
               n, data_out, exp);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (status !== 1'b1 || data_out !== exp) begin
        errors++;
        $display("FAIL mixed_hold%0d: status=%b data=%h want 1/%h",
                 c, status, data_out, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    load(D1, K3, 1);
    repeat (30) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data_out !== 64'h0 || status !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: data_out=%h status=%b want 0/0",
               data_out, status);
    end
    tick(); tick();
    rst_n = 1'b1;
    repeat (80) tick();
    checks++;
    if (data_out !== 64'h0 || status !== 1'b0 || dut.busy_q !== 1'b0)
    begin
      errors++;
      $display("FAIL midreset_idle: data=%h status=%b busy=%b want 0",
               data_out, status, dut.busy_q);
    end
  endtask

  task automatic test_abort();
    int n;
    logic [63:0] exp;
    exp = m_enc(D2, K4, 64);
    load(D1, K3, 1);
    repeat (40) tick();
    checks++;
    if (status !== 1'b0 || data_out !== 64'h0) begin
      errors++;
      $display("FAIL abort_mid: status=%b data=%h want 0/0",
               status, data_out);
    end
    load(D2, K4, 1);
    wait_done(n);
    checks++;
    if (n !== 64 || data_out !== exp) begin
      errors++;
      $display("FAIL abort_result: edges=%0d data=%h want 64/%h",
               n, data_out, exp);
    end
  endtask

  task automatic test_set_held();
    int n;
    logic [63:0] exp;
    exp = m_enc(D1, K4, 64);
    load(D1, K4, 3);
    wait_done(n);
    checks++;
    if (n !== 64 || data_out !== exp) begin
      errors++;
      $display("FAIL held_result: edges=%0d data=%h want 64/%h",
               n, data_out, exp);
    end
  endtask

  task automatic test_final_collision();
    int n;
    logic [63:0] prev;
    logic [63:0] exp;
    prev = m_enc(D1, K4, 64);
    exp  = m_enc(D2, K3, 64);
    load(D0, K4, 1);
    repeat (63) tick();
    data_in = D2;
    key     = K3;
    set     = 1'b1;
    tick();
    set = 1'b0;
    checks++;
    if (status !== 1'b0 || data_out !== prev) begin
      errors++;
      $display("FAIL collide_load: status=%b data=%h want 0/%h",
               status, data_out, prev);
    end
    wait_done(n);
    checks++;
    if (n !== 64 || data_out !== exp) begin
      errors++;
      $display("FAIL collide_result: edges=%0d data=%h want 64/%h",
               n, data_out, exp);
    end
  endtask

  initial begin
    test_reset();
    test_key_zero();
    test_key_40();
    test_rot8();
    test_mixed();
    test_reset_mid();
    test_abort();
    test_set_held();
    test_final_collision();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_encoding.md
SHIFT_ENCODING -- requirements
Module: shift_encoding

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 set  input  1  load/start strobe; sampled high on a clk edge loads operands and restarts encoding.
REQ-005 data_in  input  64 [0:63]  plaintext block; bit 0 is MSB.
REQ-006 key  input  64 [0:63]  key; byte j = bits [8j:8j+7], j=0..7.
REQ-007 data_out  output  64 [0:63]  registered encoded block.
REQ-008 status  output  1  registered done flag.
REQ-009 Parameter ROUNDS, default 64, number of encoding rounds.

Function
REQ-010 State registers SHALL be: state (64b), rk round key (64b), round counter (7b), busy (1b).
REQ-011 Edge with set=1 SHALL load state<=data_in and rk<=key, and SHALL set counter<=0, busy<=1 and status<=0. data_out SHALL hold its value.
REQ-012 Edge with set=0 and busy=1 SHALL execute one round: j = counter mod 8, s = low 6 bits of key byte j of rk (bits [8j+2:8j+7]).
REQ-013 Each round SHALL compute state <= rotl(state, s) XOR rk, where rotl moves bit i to position (i-s) mod 64 in [0:63] order.
REQ-014 The same round SHALL compute rk <= rotl(rk, 8) and counter <= counter+1.
REQ-015 On the edge executing round ROUNDS, data_out SHALL take the round result, status SHALL become 1, and busy SHALL become 0.
REQ-016 Latency: status SHALL rise on the ROUNDS-th clk edge after the first edge with set=0 following a load, which is 64 edges by default.
REQ-017 When idle (busy=0, set=0), all registers SHALL hold. status and data_out SHALL remain stable until the next load or reset.
REQ-018 If set is held high for several edges, each of those edges SHALL reload, and rounds SHALL begin only once set is low.
REQ-019 If set is reasserted mid-operation, the block SHALL abort the current operation and reload. No partial result SHALL appear on data_out.
REQ-020 If set=1 coincides with the final round edge, the load SHALL win: status stays 0 and data_out holds.
REQ-021 The round function SHALL be a pure combinational rotate/XOR, with no multi-cycle paths.

Reset
REQ-022 rst_n=0 SHALL immediately clear state, rk, counter, busy, data_out (all 0) and status (0), independent of clk.
REQ-023 A reset mid-operation SHALL discard the operation. After release, the block SHALL stay idle until set is sampled high.
REQ-024 Reset deassertion is synchronised externally; the block SHALL need no internal synchroniser.

Structure
REQ-025 A shared package SHALL hold BLOCK_W=64, BYTE_W=8, SHIFT_W=6 and ROUNDS_DEFAULT=64.
REQ-026 One sub-module, shift_round, SHALL implement the combinational round: inputs state, rk, byte index; outputs next state and next rk.
REQ-027 The top level SHALL contain only the control (counter/busy/status) and the registers.

Verification
REQ-028 data_in=64'h8967452301efcdab, key=0, set high for 1 edge then low -> after 64 edges status=1 and data_out=64'h8967452301efcdab.
REQ-029 Same data_in, key=64'h4040404040404040 (s=0, XOR 64 times) -> data_out=64'h8967452301efcdab, status=1 on edge 64, and status=0 on edges 1-63.
REQ-030 Same data_in, key=64'h0808080808080808 (rotate by 8, XOR cancels) -> data_out=data_in, and a compare against a golden reference model of REQ-012..014 SHALL match every round.
REQ-031 data_in=64'h8967452301efcdab, key=64'h0102030405060708 -> data_out equals the golden model after 64 rounds, and status holds 1 for 20 idle cycles afterwards.
REQ-032 Drop rst_n at round 30 -> data_out=0 and status=0 asynchronously, with no activity until the next set.
REQ-033 Reassert set at round 40 with new data -> status rises exactly 64 edges after set falls again, with the result for the new data only.
